// File: rtl/ether_pkg.sv
// Shared types and constants for the Ethernet receive controller:
// FSM state encoding, broadcast address, buffer word and counter widths.
package ether_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_RECV    = 2'd2,
    ST_DISCARD = 2'd3
  } rx_state_e;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int          CNT_W     = 16;
  localparam int          WORD_W    = 33;  // {last, data[31:0]}

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ether_rx_fifo.sv
// Frame buffer with commit/rollback: words become readable only once the
// write side commits them; rollback drops everything written since the last commit.
module ether_rx_fifo
  import ether_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              commit,
  input  logic              rollback,
  input  logic              rd_en,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_cmt_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_inc;
  logic              w_wr_go;

  // One slot is always left empty so that full and empty stay distinguishable.
  assign w_wr_ptr_inc = r_wr_ptr + ADDR_W'(1);
  assign full         = (w_wr_ptr_inc == r_rd_ptr);
  assign empty        = (r_rd_ptr == r_cmt_ptr);
  assign rd_data      = r_mem[r_rd_ptr];
  assign w_wr_go      = wr_en && !full;

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and a reset on the array would block RAM inference.
  always_ff @(posedge rx_clk) begin
    if (w_wr_go) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_rd_ptr  <= '0;
    end else begin
      if (rollback)     r_wr_ptr <= r_cmt_ptr;
      else if (w_wr_go) r_wr_ptr <= w_wr_ptr_inc;

      if (commit && w_wr_go) r_cmt_ptr <= w_wr_ptr_inc;

      if (rd_en && !empty) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ether_rx_ctrl.sv
// Ethernet receive controller: address filter, one-word staging, frame commit/abort
// and status counters. Define ETHER_RX_CTRL_MCAST_EN to also accept group addresses.
module ether_rx_ctrl
  import ether_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic             start_flag,
  input  logic             des_mac_valid,
  input  logic [47:0]      des_mac,
  input  logic             data_valid,
  input  logic [31:0]      data,
  input  logic             done_flag,
  input  logic             cfg_en,
  input  logic             cfg_promisc,
  input  logic [47:0]      cfg_mac,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] frm_ok_cnt,
  output logic [CNT_W-1:0] frm_drop_cnt,
  output logic [CNT_W-1:0] frm_ovf_cnt
);

  rx_state_e         r_state, w_state_nxt;
  logic [31:0]       r_stg_data;
  logic              r_stg_full;
  logic              w_stg_load, w_stg_clear;
  logic              w_wr_en, w_commit, w_rollback;
  logic [WORD_W-1:0] w_wr_data, w_rd_data;
  logic              w_full, w_empty;
  logic              w_ok_inc, w_drop_inc, w_ovf_inc;
  logic              w_mcast, w_addr_ok;

`ifdef ETHER_RX_CTRL_MCAST_EN
  assign w_mcast = des_mac[40];
`else
  assign w_mcast = 1'b0;
`endif

  assign w_addr_ok = (des_mac == cfg_mac) || (des_mac == BCAST_MAC) || cfg_promisc || w_mcast;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_data   = {1'b0, r_stg_data};
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_stg_load  = 1'b0;
    w_stg_clear = 1'b0;
    w_ok_inc    = 1'b0;
    w_drop_inc  = 1'b0;
    w_ovf_inc   = 1'b0;

    if (r_state == ST_IDLE) begin
      if (start_flag && cfg_en) w_state_nxt = ST_CHECK;
    end else if (start_flag) begin
      w_rollback  = 1'b1;
      w_stg_clear = 1'b1;
      w_drop_inc  = (r_state != ST_DISCARD);
      w_state_nxt = cfg_en ? ST_CHECK : ST_IDLE;
    end else begin
      case (r_state)
        ST_CHECK: begin
          if (des_mac_valid) begin
            w_state_nxt = w_addr_ok ? ST_RECV : ST_DISCARD;
            w_drop_inc  = !w_addr_ok;
          end
        end
        ST_RECV: begin
          if (done_flag) begin
            w_stg_clear = 1'b1;
            w_state_nxt = ST_IDLE;
            w_wr_data   = {1'b1, r_stg_data};
            if (!r_stg_full) begin
              w_rollback = 1'b1;
              w_drop_inc = 1'b1;
            end else if (w_full) begin
              w_rollback  = 1'b1;
              w_ovf_inc   = 1'b1;
              w_state_nxt = ST_DISCARD;
            end else begin
              w_wr_en  = 1'b1;
              w_commit = 1'b1;
              w_ok_inc = 1'b1;
            end
          end else if (data_valid) begin
            if (r_stg_full && w_full) begin
              w_rollback  = 1'b1;
              w_ovf_inc   = 1'b1;
              w_stg_clear = 1'b1;
              w_state_nxt = ST_DISCARD;
            end else begin
              w_wr_en    = r_stg_full;
              w_stg_load = 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          if (done_flag) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_stg_data   <= '0;
      r_stg_full   <= 1'b0;
      frm_ok_cnt   <= '0;
      frm_drop_cnt <= '0;
      frm_ovf_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stg_clear) begin
        r_stg_full <= 1'b0;
      end else if (w_stg_load) begin
        r_stg_data <= data;
        r_stg_full <= 1'b1;
      end
      if (w_ok_inc)   frm_ok_cnt   <= sat_inc(frm_ok_cnt);
      if (w_drop_inc) frm_drop_cnt <= sat_inc(frm_drop_cnt);
      if (w_ovf_inc)  frm_ovf_cnt  <= sat_inc(frm_ovf_cnt);
    end
  end

  ether_rx_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .rx_clk   (rx_clk),
    .rst      (rst),
    .wr_en    (w_wr_en),
    .wr_data  (w_wr_data),
    .commit   (w_commit),
    .rollback (w_rollback),
    .rd_en    (m_valid && m_ready),
    .full     (w_full),
    .empty    (w_empty),
    .rd_data  (w_rd_data)
  );

  assign m_valid = !w_empty;
  assign m_last  = w_rd_data[32];
  assign m_data  = w_rd_data[31:0];

endmodule

// File: tb/tb_ether_rx_ctrl.sv
// Scoreboard bench for ether_rx_ctrl with an 8-entry buffer; a monitor pops the
// expected-word queue whenever the host stream handshakes.
module tb_ether_rx_ctrl;

  localparam int          ADDR_W  = 3;
  localparam logic [47:0] MY_MAC  = 48'h0200_0000_0001;
  localparam logic [47:0] OTH_MAC = 48'h0200_0000_0002;
  localparam logic [47:0] BC_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MC_MAC  = 48'h0100_5E00_0001;
`ifdef ETHER_RX_CTRL_MCAST_EN
  localparam int MC = 1;
`else
  localparam int MC = 0;
`endif

  logic        rx_clk = 1'b0;
  logic        rst;
  logic        start_flag, des_mac_valid, data_valid, done_flag;
  logic [47:0] des_mac, cfg_mac;
  logic [31:0] data, m_data;
  logic        cfg_en, cfg_promisc, m_valid, m_ready, m_last;
  logic [15:0] frm_ok_cnt, frm_drop_cnt, frm_ovf_cnt;

  logic [32:0] sb [$];
  logic [32:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 rx_clk = ~rx_clk;

  ether_rx_ctrl #(.ADDR_W(ADDR_W)) dut (
    .rx_clk        (rx_clk),
    .rst           (rst),
    .start_flag    (start_flag),
    .des_mac_valid (des_mac_valid),
    .des_mac       (des_mac),
    .data_valid    (data_valid),
    .data          (data),
    .done_flag     (done_flag),
    .cfg_en        (cfg_en),
    .cfg_promisc   (cfg_promisc),
    .cfg_mac       (cfg_mac),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .frm_ok_cnt    (frm_ok_cnt),
    .frm_drop_cnt  (frm_drop_cnt),
    .frm_ovf_cnt   (frm_ovf_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted stream word must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge rx_clk);
      if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word", {m_last, m_data});
        end else begin
          mon_exp = sb.pop_front();
          check("stream_word", {m_last, m_data}, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic frame_head(input logic [47:0] mac);
    start_flag = 1'b1;
    tick();
    start_flag    = 1'b0;
    des_mac_valid = 1'b1;
    des_mac       = mac;
    tick();
    des_mac_valid = 1'b0;
  endtask

  task automatic frame_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data       = base + 32'(i);
      tick();
      data_valid = 1'b0;
      if (i % 2 == 1) tick();
    end
  endtask

  task automatic frame_tail();
    done_flag = 1'b1;
    tick();
    done_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] mac, input int n, input logic [31:0] base,
                            input bit accept);
    if (accept)
      for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), base + 32'(i)});
    frame_head(mac);
    frame_words(n, base);
    frame_tail();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    repeat (3) tick();
    check(name, 64'(sb.size()), 64'd0);
    check({name, "_idle"}, 64'(m_valid), 64'd0);
  endtask

  task automatic check_cnt(input string name, input int ok, input int drop, input int ovf);
    check({name, "_ok"},   64'(frm_ok_cnt),   64'(ok));
    check({name, "_drop"}, 64'(frm_drop_cnt), 64'(drop));
    check({name, "_ovf"},  64'(frm_ovf_cnt),  64'(ovf));
  endtask

  initial begin
    rst = 1'b0;
    start_flag = 0; des_mac_valid = 0; data_valid = 0; done_flag = 0;
    des_mac = '0; data = '0;
    cfg_en = 1'b1; cfg_promisc = 1'b0; cfg_mac = MY_MAC; m_ready = 1'b1;
    repeat (3) tick();
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check_cnt("reset", 0, 0, 0);
    rst = 1'b1;
    tick();

    // Unicast to own address, three words A,B,C.
    send_frame(MY_MAC, 3, 32'hA000_0000, 1'b1);
    drain("unicast");
    check_cnt("unicast", 1, 0, 0);

    // Foreign address dropped, then accepted in promiscuous mode.
    send_frame(OTH_MAC, 3, 32'hB000_0000, 1'b0);
    repeat (4) tick();
    check("foreign_no_valid", 64'(m_valid), 64'd0);
    check_cnt("foreign", 1, 1, 0);
    cfg_promisc = 1'b1;
    send_frame(OTH_MAC, 3, 32'hB100_0000, 1'b1);
    drain("promisc");
    cfg_promisc = 1'b0;
    check_cnt("promisc", 2, 1, 0);

    // Single-word broadcast frame.
    send_frame(BC_MAC, 1, 32'hC000_0000, 1'b1);
    drain("bcast");
    check_cnt("bcast", 3, 1, 0);

    // Overflow: 10 words into 7 usable slots with the host stalled.
    m_ready = 1'b0;
    send_frame(MY_MAC, 10, 32'hD000_0000, 1'b0);
    repeat (3) tick();
    check("ovf_no_valid", 64'(m_valid), 64'd0);
    check_cnt("ovf", 3, 1, 1);
    send_frame(MY_MAC, 2, 32'hD100_0000, 1'b1);
    check("commit_visible", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    drain("after_ovf");
    check_cnt("after_ovf", 4, 1, 1);

    // Frame aborted after two words by a new start, followed by a full frame.
    frame_head(MY_MAC);
    frame_words(2, 32'hE000_0000);
    send_frame(MY_MAC, 3, 32'hE100_0000, 1'b1);
    drain("abort");
    check_cnt("abort", 5, 2, 1);

    // Enable dropped mid-frame: frame completes; next start is ignored.
    frame_head(MY_MAC);
    cfg_en = 1'b0;
    for (int i = 0; i < 2; i++) sb.push_back({(i == 1), 32'hF000_0000 + 32'(i)});
    frame_words(2, 32'hF000_0000);
    frame_tail();
    drain("en_midframe");
    send_frame(MY_MAC, 2, 32'hF100_0000, 1'b0);
    repeat (3) tick();
    check("disabled_no_valid", 64'(m_valid), 64'd0);
    check_cnt("disabled", 6, 2, 1);
    cfg_en = 1'b1;

    // End of frame with no data staged.
    frame_head(MY_MAC);
    frame_tail();
    repeat (3) tick();
    check_cnt("empty_frame", 6, 3, 1);

    // Multicast group address.
    send_frame(MC_MAC, 2, 32'h1100_0000, MC == 1);
    drain("mcast");
    check_cnt("mcast", 6 + MC, 4 - MC, 1);

    // Back-to-back frames while the host drains: commit and pop overlap.
    send_frame(MY_MAC, 5, 32'h2200_0000, 1'b1);
    send_frame(BC_MAC, 2, 32'h2300_0000, 1'b1);
    drain("b2b");
    check_cnt("b2b", 8 + MC, 4 - MC, 1);

    // Reset during word 2 with a committed frame pending.
    m_ready = 1'b0;
    send_frame(MY_MAC, 2, 32'h3300_0000, 1'b1);
    frame_head(MY_MAC);
    data_valid = 1'b1; data = 32'h3400_0000;
    tick();
    data = 32'h3400_0001;
    rst  = 1'b0;
    #1;
    data_valid = 1'b0;
    sb.delete();
    tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check_cnt("rst_mid", 0, 0, 0);
    rst = 1'b1;
    tick();
    m_ready = 1'b1;
    send_frame(MY_MAC, 3, 32'h3500_0000, 1'b1);
    drain("post_rst");
    check_cnt("post_rst", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
